// File: rtl/inst_rom_loader.sv
// Boot-loaded instruction ROM: packs a big-endian byte stream into 32-bit words,
// serves combinational fetches to the core, and holds the core in reset until a load completes.
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic [7:0]        ld_byte,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    input  logic              rom_ce,
    input  logic [31:0]       rom_addr,
    output logic [31:0]       rom_data,
    output logic              cpu_rst
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] word_cnt_q, word_cnt_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            len_legal;
    logic            start_ok;
    logic            start_bad;
    logic            accept;
    logic            word_we;
    logic            last_byte;

    logic [31:0]     mem [DEPTH];

    assign len_legal = (ld_len != '0) && (ld_len <= LEN_MAX);
    assign start_ok  = ld_start && len_legal && (state_q != S_LOAD);
    assign start_bad = ld_start && !len_legal && (state_q != S_LOAD);
    assign accept    = ld_valid && (state_q == S_LOAD);
    assign word_we   = accept && (byte_cnt_q == 2'd3);
    assign last_byte = word_we && (word_cnt_q == (len_q - LEN_ONE));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok)  state_d = S_LOAD;
            S_LOAD:  if (last_byte) state_d = S_RUN;
            S_RUN:   if (start_ok)  state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: the core runs only once a complete image is in place
    always_comb begin
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        cpu_rst  = 1'b1;
        unique case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                ld_ready = 1'b1;
                ld_busy  = 1'b1;
            end
            S_RUN:   cpu_rst = 1'b0;
            default: ;
        endcase
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        err_d      = err_q;
        done_d     = last_byte;

        if (start_ok) begin
            len_d      = ld_len;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            shift_d    = '0;
            err_d      = 1'b0;
        end else if (start_bad) begin
            err_d      = 1'b1;
        end

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], ld_byte};
            if (word_we) begin
                word_cnt_d = word_cnt_q + LEN_ONE;
                shift_d    = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ld_done = done_q;
    assign ld_err  = err_q;

    // NOTE: the array has no reset; its contents must survive a reset so completed words stay valid.
    always_ff @(posedge clk) begin
        if (word_we) begin
            mem[word_cnt_q[ADDR_W-1:0]] <= {shift_q, ld_byte};
        end
    end

    // Fetch is combinational; the byte offset and high PC bits are don't-cares (address wraps).
    assign rom_data = rom_ce ? mem[rom_addr[ADDR_W+1:2]] : 32'h0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr[31:ADDR_W+2], rom_addr[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed self-checking bench for inst_rom_loader: reset state, byte packing, legality,
// reload from RUN, mid-load reset and a full-depth fill with address wrap.
module tb_inst_rom_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic [7:0]        ld_byte;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;
    logic              ld_err;
    logic              rom_ce;
    logic [31:0]       rom_addr;
    logic [31:0]       rom_data;
    logic              cpu_rst;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        ce;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab [6];

    inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_len   (ld_len),
        .ld_byte  (ld_byte),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_busy  (ld_busy),
        .ld_done  (ld_done),
        .ld_err   (ld_err),
        .rom_ce   (rom_ce),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cpu_rst  (cpu_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake and done-pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst && ld_valid && ld_ready) acc_cnt++;
        if (ld_done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_load(input int len);
        ld_start = 1'b1;
        ld_len   = (ADDR_W + 1)'(len);
        step();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int bubbles);
        int guard;
        ld_valid = 1'b0;
        repeat (bubbles) step();
        ld_valid = 1'b1;
        ld_byte  = b;
        guard = 0;
        while (!ld_ready && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
        step();
        ld_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_bubble);
        for (int k = 3; k >= 0; k--) begin
            send(w[8*k +: 8], (max_bubble == 0) ? 0 : int'($urandom_range(0, max_bubble)));
        end
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        rom_addr = addr;
        rom_ce   = 1'b1;
        #1;
        check(name, rom_data, exp);
    endtask

    initial begin
        int acc0;
        int done0;

        rst      = 1'b0;
        ld_start = 1'b0;
        ld_len   = '0;
        ld_byte  = 8'h00;
        ld_valid = 1'b0;
        rom_ce   = 1'b0;
        rom_addr = '0;

        rd_tab[0] = '{"rd_word1",      32'd4,                 1'b1, 32'h3403_0002};
        rd_tab[1] = '{"rd_word0",      32'd0,                 1'b1, 32'h3402_0001};
        rd_tab[2] = '{"rd_ce_off",     32'd4,                 1'b0, 32'h0000_0000};
        rd_tab[3] = '{"rd_byte_off",   32'd7,                 1'b1, 32'h3403_0002};
        rd_tab[4] = '{"rd_wrap_high",  32'd4 + 32'(4*DEPTH),  1'b1, 32'h3403_0002};
        rd_tab[5] = '{"rd_ce_off_w0",  32'd0,                 1'b0, 32'h0000_0000};

        // Reset values
        #3;
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_ready",   32'(ld_ready), 32'd0);
        check("rst_busy",    32'(ld_busy), 32'd0);
        check("rst_done",    32'(ld_done), 32'd0);
        check("rst_err",     32'(ld_err), 32'd0);
        step();
        rst = 1'b1;
        step();

        // 1: basic two-word load, back-to-back bytes
        start_load(2);
        check("t1_busy", 32'(ld_busy), 32'd1);
        check("t1_cpu_rst_load", 32'(cpu_rst), 32'd1);
        done0 = done_cnt;
        send_word(32'h3402_0001, 0);
        send_word(32'h3403_0002, 0);
        check("t1_done_pulse", 32'(ld_done), 32'd1);
        check("t1_cpu_rst_run", 32'(cpu_rst), 32'd0);
        check("t1_busy_off", 32'(ld_busy), 32'd0);
        check("t1_ready_off", 32'(ld_ready), 32'd0);
        step();
        check("t1_done_one_cycle", 32'(ld_done), 32'd0);
        check("t1_done_count", 32'(done_cnt - done0), 32'd1);
        for (int i = 0; i < 6; i++) begin
            rom_addr = rd_tab[i].addr;
            rom_ce   = rd_tab[i].ce;
            #1;
            check(rd_tab[i].name, rom_data, rd_tab[i].exp);
        end
        rom_ce = 1'b0;

        // 2: stray bytes in IDLE and RUN, then a bubbly reload of the same image
        rst = 1'b0;
        step();
        rst = 1'b1;
        acc0  = acc_cnt;
        done0 = done_cnt;
        ld_valid = 1'b1;
        ld_byte  = 8'hFF;
        repeat (3) step();
        ld_valid = 1'b0;
        check("t2_idle_no_accept", 32'(acc_cnt - acc0), 32'd0);
        start_load(2);
        send_word(32'h3402_0001, 2);
        send_word(32'h3403_0002, 2);
        ld_valid = 1'b1;
        ld_byte  = 8'hEE;
        repeat (3) step();
        ld_valid = 1'b0;
        step();
        check("t2_accept_count", 32'(acc_cnt - acc0), 32'd8);
        check("t2_done_count", 32'(done_cnt - done0), 32'd1);
        read_chk("t2_word0", 32'd0, 32'h3402_0001);
        read_chk("t2_word1", 32'd4, 32'h3403_0002);
        rom_ce = 1'b0;

        // 3: illegal lengths from IDLE, then a legal one clears the error
        rst = 1'b0;
        step();
        rst = 1'b1;
        start_load(0);
        check("t3_err_len0", 32'(ld_err), 32'd1);
        check("t3_idle_len0", 32'(ld_busy), 32'd0);
        check("t3_cpu_rst", 32'(cpu_rst), 32'd1);
        start_load(DEPTH + 1);
        check("t3_err_over", 32'(ld_err), 32'd1);
        check("t3_idle_over", 32'(ld_busy), 32'd0);
        start_load(2);
        check("t3_err_cleared", 32'(ld_err), 32'd0);
        check("t3_busy_legal", 32'(ld_busy), 32'd1);
        send_word(32'h3402_0001, 0);
        send_word(32'h3403_0002, 0);
        step();
        start_load(DEPTH + 1);
        check("t3_err_in_run", 32'(ld_err), 32'd1);
        check("t3_stays_run", 32'(cpu_rst), 32'd0);

        // 4: reload from RUN; a start pulse mid-load must be ignored
        done0 = done_cnt;
        start_load(1);
        check("t4_cpu_rst_reload", 32'(cpu_rst), 32'd1);
        send(8'hDE, 0);
        send(8'hAD, 0);
        start_load(2);
        check("t4_still_busy", 32'(ld_busy), 32'd1);
        send(8'hBE, 0);
        send(8'hEF, 0);
        check("t4_done", 32'(ld_done), 32'd1);
        step();
        check("t4_cpu_rst_after", 32'(cpu_rst), 32'd0);
        check("t4_done_count", 32'(done_cnt - done0), 32'd1);
        read_chk("t4_word0", 32'd0, 32'hDEAD_BEEF);
        read_chk("t4_word1_kept", 32'd4, 32'h3403_0002);
        rom_ce = 1'b0;

        // 5: asynchronous reset in the middle of the second word
        start_load(2);
        send_word(32'h1122_3344, 0);
        send(8'h55, 0);
        rst = 1'b0;
        #1;
        check("t5_async_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t5_async_busy", 32'(ld_busy), 32'd0);
        check("t5_async_ready", 32'(ld_ready), 32'd0);
        read_chk("t5_full_word_kept", 32'd0, 32'h1122_3344);
        read_chk("t5_partial_dropped", 32'd4, 32'h3403_0002);
        step();
        rst = 1'b1;
        step();
        start_load(1);
        send_word(32'hAABB_CCDD, 0);
        step();
        read_chk("t5_restart_word0", 32'd0, 32'hAABB_CCDD);
        read_chk("t5_restart_word1", 32'd4, 32'h3403_0002);
        check("t5_run", 32'(cpu_rst), 32'd0);
        rom_ce = 1'b0;

        // 6: full-depth load, word i = i
        done0 = done_cnt;
        start_load(DEPTH);
        check("t6_busy", 32'(ld_busy), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            send_word(32'(i), 0);
        end
        check("t6_done", 32'(ld_done), 32'd1);
        step();
        check("t6_done_count", 32'(done_cnt - done0), 32'd1);
        check("t6_cpu_rst", 32'(cpu_rst), 32'd0);
        read_chk("t6_last_word", 32'(4 * (DEPTH - 1)), 32'(DEPTH - 1));
        read_chk("t6_wrap_to_0", 32'(4 * DEPTH), 32'd0);
        read_chk("t6_word1", 32'd4, 32'd1);
        read_chk("t6_mid_word", 32'(4 * 513), 32'd513);
        rom_ce = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
